// File: rtl/acondicionador_botones.sv
// Button conditioner: per-button 2-flop synchronizer, debounce FSM, press/long-press pulses,
// debounced levels and a both-buttons pulse. Every output is a register.
module acondicionador_botones #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 250000000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic Boton_Comida,
    input  logic Boton_Medicina,
    output logic Comida_Pulso,
    output logic Medicina_Pulso,
    output logic Comida_Nivel,
    output logic Medicina_Nivel,
    output logic Comida_Largo,
    output logic Medicina_Largo,
    output logic Ambos_Pulso
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [DW-1:0] DEB_ONE   = DW'(1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam bit            DEB_INMEDIATO = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        StSuelto,
        StConfirmaPresion,
        StPresionado,
        StConfirmaSuelta
    } estado_t;

    logic [1:0] w_raw;
    logic [1:0] w_pulso;
    logic [1:0] w_nivel;
    logic [1:0] w_largo;

    // Index 0 = food, index 1 = medicine.
    assign w_raw = {Boton_Medicina, Boton_Comida};

    for (genvar g = 0; g < 2; g++) begin : g_boton
        logic          r_sync1;
        logic          r_sync2;
        logic          w_p;
        estado_t       r_estado;
        estado_t       w_estado_sig;
        logic [DW-1:0] r_cuenta;
        logic [DW-1:0] w_cuenta_sig;
        logic [HW-1:0] r_hold;
        logic [HW-1:0] w_hold_sig;
        logic          w_acepta;
        logic          w_nivel_sig;
        logic          w_largo_sig;
        logic          r_pulso;
        logic          r_nivel;
        logic          r_largo;

        // Synchronizer resets to the raw "released" level; polarity is normalised after it.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_sync1 <= BTN_ACTIVE_LOW;
                r_sync2 <= BTN_ACTIVE_LOW;
            end else begin
                r_sync1 <= w_raw[g];
                r_sync2 <= r_sync1;
            end
        end

        assign w_p = r_sync2 ^ BTN_ACTIVE_LOW;

        always_comb begin
            w_estado_sig = r_estado;
            w_cuenta_sig = r_cuenta;
            w_acepta     = 1'b0;
            unique case (r_estado)
                StSuelto: begin
                    if (w_p) begin
                        if (DEB_INMEDIATO) begin
                            w_estado_sig = StPresionado;
                            w_cuenta_sig = '0;
                            w_acepta     = 1'b1;
                        end else begin
                            w_estado_sig = StConfirmaPresion;
                            w_cuenta_sig = DEB_ONE;
                        end
                    end
                end
                StConfirmaPresion: begin
                    if (!w_p) begin
                        w_estado_sig = StSuelto;
                        w_cuenta_sig = '0;
                    end else if (r_cuenta == DEB_LAST) begin
                        w_estado_sig = StPresionado;
                        w_cuenta_sig = '0;
                        w_acepta     = 1'b1;
                    end else begin
                        w_cuenta_sig = r_cuenta + DEB_ONE;
                    end
                end
                StPresionado: begin
                    if (!w_p) begin
                        if (DEB_INMEDIATO) begin
                            w_estado_sig = StSuelto;
                            w_cuenta_sig = '0;
                        end else begin
                            w_estado_sig = StConfirmaSuelta;
                            w_cuenta_sig = DEB_ONE;
                        end
                    end
                end
                StConfirmaSuelta: begin
                    if (w_p) begin
                        w_estado_sig = StPresionado;
                        w_cuenta_sig = '0;
                    end else if (r_cuenta == DEB_LAST) begin
                        w_estado_sig = StSuelto;
                        w_cuenta_sig = '0;
                    end else begin
                        w_cuenta_sig = r_cuenta + DEB_ONE;
                    end
                end
                default: begin
                    w_estado_sig = StSuelto;
                    w_cuenta_sig = '0;
                end
            endcase
        end

        // Hold time keeps running through release bounces; only a fresh acceptance restarts it.
        always_comb begin
            w_hold_sig  = r_hold;
            w_largo_sig = 1'b0;
            if (w_acepta || (w_estado_sig == StSuelto)) begin
                w_hold_sig = '0;
            end else if (r_nivel && (r_hold != HOLD_MAX)) begin
                w_hold_sig = r_hold + HOLD_ONE;
            end
            if (r_nivel && (r_hold == HOLD_LAST)) begin
                w_largo_sig = 1'b1;
            end
            w_nivel_sig = (w_estado_sig == StPresionado) || (w_estado_sig == StConfirmaSuelta);
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_estado <= StSuelto;
                r_cuenta <= '0;
                r_hold   <= '0;
                r_pulso  <= 1'b0;
                r_nivel  <= 1'b0;
                r_largo  <= 1'b0;
            end else begin
                r_estado <= w_estado_sig;
                r_cuenta <= w_cuenta_sig;
                r_hold   <= w_hold_sig;
                r_pulso  <= w_acepta;
                r_nivel  <= w_nivel_sig;
                r_largo  <= w_largo_sig;
            end
        end

        assign w_pulso[g] = r_pulso;
        assign w_nivel[g] = r_nivel;
        assign w_largo[g] = r_largo;
    end

    logic w_ambos;
    logic r_ambos_prev;
    logic r_ambos;

    assign w_ambos = &w_nivel;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ambos_prev <= 1'b0;
            r_ambos      <= 1'b0;
        end else begin
            r_ambos_prev <= w_ambos;
            r_ambos      <= w_ambos & ~r_ambos_prev;
        end
    end

    assign Comida_Pulso   = w_pulso[0];
    assign Medicina_Pulso = w_pulso[1];
    assign Comida_Nivel   = w_nivel[0];
    assign Medicina_Nivel = w_nivel[1];
    assign Comida_Largo   = w_largo[0];
    assign Medicina_Largo = w_largo[1];
    assign Ambos_Pulso    = r_ambos;

endmodule

// File: tb/tb_acondicionador_botones.sv
// Bench for acondicionador_botones with D = 4, H = 20, active-high buttons: scenario table
// expanded into per-cycle expected vectors, queued at drive time and checked after each edge.
module tb_acondicionador_botones;

    logic clk;
    logic reset;
    logic Boton_Comida;
    logic Boton_Medicina;
    logic Comida_Pulso;
    logic Medicina_Pulso;
    logic Comida_Nivel;
    logic Medicina_Nivel;
    logic Comida_Largo;
    logic Medicina_Largo;
    logic Ambos_Pulso;

    acondicionador_botones #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (20),
        .BTN_ACTIVE_LOW (1'b0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .Boton_Comida  (Boton_Comida),
        .Boton_Medicina(Boton_Medicina),
        .Comida_Pulso  (Comida_Pulso),
        .Medicina_Pulso(Medicina_Pulso),
        .Comida_Nivel  (Comida_Nivel),
        .Medicina_Nivel(Medicina_Nivel),
        .Comida_Largo  (Comida_Largo),
        .Medicina_Largo(Medicina_Largo),
        .Ambos_Pulso   (Ambos_Pulso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raw comida high for edges [c_on, c_off) minus a low glitch; medicina toggles every two
    // edges before m_tog. Expected edges: level high for edges [rise, fall); 0 = never.
    typedef struct {
        string nm;
        int    ncyc;
        int    c_on, c_off, c_gl, c_gl_len;
        int    m_on, m_off, m_tog;
        int    e_cp, e_cn_r, e_cn_f, e_cl;
        int    e_mp, e_mn_r, e_mn_f, e_ml;
        int    e_amb;
    } vec_t;

    typedef struct {
        string      nm;
        int         k;
        logic [6:0] exp;
    } sb_t;

    sb_t  sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic [6:0] w_obs;

    assign w_obs = {Ambos_Pulso, Medicina_Largo, Medicina_Nivel, Medicina_Pulso,
                    Comida_Largo, Comida_Nivel, Comida_Pulso};

    function automatic logic raw_c(input vec_t v, input int k);
        if (v.c_on == 0 || k < v.c_on) return 1'b0;
        if (v.c_off != 0 && k >= v.c_off) return 1'b0;
        if (v.c_gl != 0 && k >= v.c_gl && k < v.c_gl + v.c_gl_len) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic raw_m(input vec_t v, input int k);
        if (v.m_on == 0 || k < v.m_on) return 1'b0;
        if (v.m_off != 0 && k >= v.m_off) return 1'b0;
        if (k < v.m_tog) return (((k - v.m_on) / 2) % 2) == 0;
        return 1'b1;
    endfunction

    function automatic logic lvl(input int k, input int r, input int f);
        return (r != 0) && (k >= r) && ((f == 0) || (k < f));
    endfunction

    function automatic logic [6:0] expect_vec(input vec_t v, input int k);
        return {(k == v.e_amb), (k == v.e_ml), lvl(k, v.e_mn_r, v.e_mn_f), (k == v.e_mp),
                (k == v.e_cl), lvl(k, v.e_cn_r, v.e_cn_f), (k == v.e_cp)};
    endfunction

    // Drive one cycle and queue what the outputs must be right after the coming edge.
    task automatic step(input logic rst, input logic bc, input logic bm,
                        input logic [6:0] e, input string nm, input int k);
        reset          = rst;
        Boton_Comida   = bc;
        Boton_Medicina = bm;
        sb_q.push_back('{nm, k, e});
        @(posedge clk);
        #2;
    endtask

    task automatic run_vec(input vec_t v);
        for (int k = 1; k <= 3; k++) step(1'b1, 1'b0, 1'b0, 7'b0, {v.nm, "/reset"}, k);
        for (int k = 1; k <= v.ncyc; k++) begin
            step(1'b0, raw_c(v, k), raw_m(v, k), expect_vec(v, k), v.nm, k);
        end
    endtask

    initial begin : monitor
        sb_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if (w_obs !== e.exp) begin
                    n_err++;
                    $display("FAIL %s edge %0d: outputs {amb,ml,mn,mp,cl,cn,cp} got %b want %b",
                             e.nm, e.k, w_obs, e.exp);
                end
            end
        end
    end

    vec_t tbl[8];

    initial begin : driver
        logic [6:0] e;
        reset          = 1'b1;
        Boton_Comida   = 1'b0;
        Boton_Medicina = 1'b0;

        //          name          ncyc c_on off gl len m_on off tog  cp cnr cnf cl  mp mnr mnf ml amb
        tbl[0] = '{"idle",         10, 0,  0,  0, 0,  0,  0,  0,   0, 0,  0,  0,  0, 0,  0,  0,  0};
        tbl[1] = '{"comida_12",    25, 1,  13, 0, 0,  0,  0,  0,   6, 6,  18, 0,  0, 0,  0,  0,  0};
        tbl[2] = '{"med_bounce",   30, 0,  0,  0, 0,  1,  0,  13,  0, 0,  0,  0,  18, 18, 0, 0,  0};
        tbl[3] = '{"glitch_40",    50, 1,  41, 15, 2, 0,  0,  0,   6, 6,  46, 26, 0, 0,  0,  0,  0};
        tbl[4] = '{"both",         30, 1,  0,  0, 0,  1,  0,  0,   6, 6,  0,  26, 6, 6,  0,  26, 7};
        tbl[5] = '{"short_3",      12, 1,  4,  0, 0,  0,  0,  0,   0, 0,  0,  0,  0, 0,  0,  0,  0};
        tbl[6] = '{"exact_4",      15, 1,  5,  0, 0,  0,  0,  0,   6, 6,  10, 0,  0, 0,  0,  0,  0};
        tbl[7] = '{"stagger",      35, 1,  0,  0, 0,  5,  0,  0,   6, 6,  0,  26, 10, 10, 0, 30, 11};

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // Reset pulse in the middle of a held press: fresh acceptance counted from release.
        for (int k = 1; k <= 3; k++) step(1'b1, 1'b0, 1'b0, 7'b0, "rst_mid/reset", k);
        for (int k = 1; k <= 40; k++) begin
            e = '0;
            e[0] = (k == 6) || (k == 16);
            e[1] = ((k >= 6) && (k < 10)) || (k >= 16);
            e[2] = (k == 36);
            step((k == 10), 1'b1, 1'b0, e, "rst_mid", k);
        end

        // Held through a multi-cycle reset: no output until a new full debounce after release.
        for (int k = 1; k <= 3; k++) step(1'b1, 1'b1, 1'b1, 7'b0, "held_rst/reset", k);
        for (int k = 1; k <= 8; k++) begin
            e = '0;
            e[0] = (k == 6);
            e[1] = (k >= 6);
            e[3] = (k == 6);
            e[4] = (k >= 6);
            e[6] = (k == 7);
            step(1'b0, 1'b1, 1'b1, e, "held_rst", k);
        end

        #5;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
